fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC register and issues one-outstanding instruction reads to a multi-cycle instruction memory.
- Buffers one fetched instruction and presents it, with its PC+2, to decode under a valid/stall handshake.
- Handles branch/jump redirects from execute, halt (createDump) from decode, and misaligned-target errors.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_pc_reg.sv | 30 +++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode constants: FSM encoding, instruction width, NOP/HALT opcodes.
// Imported by the fetch stage and by the control unit so both agree on encodings.
package fetch_unit_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 5;

    localparam logic [OPC_W-1:0]   OPC_HALT = 5'b00000;
    localparam logic [OPC_W-1:0]   OPC_NOP  = 5'b00001;
    localparam logic [INSTR_W-1:0] NOP_WORD = {OPC_NOP, {(INSTR_W-OPC_W){1'b0}}};

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FULL   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: async reset to RESET_PC, redirect load has priority over +2 increment.
// Latency: new PC visible the cycle after load/inc. No backpressure; caller gates inc.
// pc_plus2 is combinational and wraps modulo 2^16.
module fetch_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus2
);

    assign pc_plus2 = pc + ADDR_W'(2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc_plus2;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding memory read, one buffered instruction handed to decode.
// Latency: memory latency + 2 cycles per instruction. Backpressure: stall holds the buffer,
// no new request issues until the buffered word is consumed.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    output logic               memReq,
    output logic [ADDR_W-1:0]  memAddr,
    input  logic               memAck,
    input  logic               memValid,
    input  logic [INSTR_W-1:0] memData,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pcPlus2,
    output logic               instrValid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirectPC,
    input  logic               halt,
    output logic               err
);

    fetch_state_t      state;
    logic              squash;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              redir_take;
    logic              redir_bad;
    logic              pc_load;
    logic              accept_dat;

    assign redir_take = redirect && (state != ST_HALTED);
    assign redir_bad  = redir_take && redirectPC[0];
    assign pc_load    = redir_take && !redirectPC[0];
    assign accept_dat = (state == ST_WAIT) && memValid && !squash && !redir_take;

    // A misaligned target never reaches the PC, so memAddr stays even.
    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .load_pc  (redirectPC),
        .inc      (accept_dat),
        .pc       (pc),
        .pc_plus2 (pc_next)
    );

    assign memAddr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_FETCH;
            squash      <= 1'b0;
            memReq      <= 1'b0;
            instruction <= NOP_INSTR;
            pcPlus2     <= '0;
            instrValid  <= 1'b0;
            err         <= 1'b0;
        end else if (redir_take) begin
            instrValid  <= 1'b0;
            instruction <= NOP_INSTR;
            if (redir_bad) begin
                err    <= 1'b1;
                squash <= 1'b0;
                memReq <= 1'b0;
                state  <= ST_HALTED;
            end else begin
                case (state)
                    ST_FETCH: begin
                        memReq <= 1'b0;
                        if (memReq && memAck) begin
                            squash <= 1'b1;
                            state  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        // Stale data landing with the redirect is dropped here; otherwise
                        // squash would wait for a second response that never comes.
                        if (memValid) begin
                            squash <= 1'b0;
                            memReq <= 1'b1;
                            state  <= ST_FETCH;
                        end else begin
                            squash <= 1'b1;
                        end
                    end
                    ST_FULL: begin
                        memReq <= 1'b1;
                        state  <= ST_FETCH;
                    end
                    default: ;
                endcase
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    // memReq is low for one cycle after reset or a FETCH redirect.
                    if (!memReq) begin
                        memReq <= 1'b1;
                    end else if (memAck) begin
                        memReq <= 1'b0;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (memValid) begin
                        if (squash) begin
                            squash <= 1'b0;
                            memReq <= 1'b1;
                            state  <= ST_FETCH;
                        end else begin
                            instruction <= memData;
                            pcPlus2     <= pc_next;
                            instrValid  <= 1'b1;
                            state       <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (halt && instrValid) begin
                        instrValid  <= 1'b0;
                        instruction <= NOP_INSTR;
                        memReq      <= 1'b0;
                        state       <= ST_HALTED;
                    end else if (!stall) begin
                        instrValid  <= 1'b0;
                        instruction <= NOP_INSTR;
                        memReq      <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_HALTED: begin
                    memReq     <= 1'b0;
                    instrValid <= 1'b0;
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        memReq;
    logic [15:0] memAddr;
    logic        memAck;
    logic        memValid;
    logic [15:0] memData;
    logic [15:0] instruction;
    logic [15:0] pcPlus2;
    logic        instrValid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        halt;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:32767];
    int          mem_lat = 1;
    int          pend_cnt = 0;
    logic [15:0] pend_dat;

    fetch_unit #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0800)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memAck      (memAck),
        .memValid    (memValid),
        .memData     (memData),
        .instruction (instruction),
        .pcPlus2     (pcPlus2),
        .instrValid  (instrValid),
        .stall       (stall),
        .redirect    (redirect),
        .redirectPC  (redirectPC),
        .halt        (halt),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks a request, returns data mem_lat cycles later; keeps a pending read across reset.
    always @(negedge clk) begin
        memAck   = 1'b0;
        memValid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                memValid = 1'b1;
                memData  = pend_dat;
            end
        end else if (memReq) begin
            memAck   = 1'b1;
            pend_dat = mem[memAddr[15:1]];
            pend_cnt = mem_lat;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!ok) begin
                step();
                ok = instrValid;
            end
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!ok) begin
                step();
                ok = memReq;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPC = 16'h0; halt = 1'b0;
        memAck = 1'b0; memValid = 1'b0; memData = 16'h0;
        step(); step();
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq got %b want 0", memReq); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_instrValid got %b want 0", instrValid); end
        checks++; if (instruction !== 16'h0800) begin errors++; $display("FAIL reset_instruction got %h want 0800", instruction); end
        checks++; if (pcPlus2 !== 16'h0000) begin errors++; $display("FAIL reset_pcPlus2 got %h want 0000", pcPlus2); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        wait_req(ok);
        checks++; if (!ok || memAddr !== 16'h0000) begin errors++; $display("FAIL basic_addr0 got %h ok=%b want 0000", memAddr, ok); end
        wait_valid(ok);
        checks++; if (!ok || instruction !== 16'h4101 || pcPlus2 !== 16'h0002)
            begin errors++; $display("FAIL basic_instr0 got %h/%h want 4101/0002", instruction, pcPlus2); end
        step();
        checks++; if (instrValid !== 1'b0 || memReq !== 1'b1 || memAddr !== 16'h0002)
            begin errors++; $display("FAIL basic_refetch got v=%b req=%b addr=%h want 0/1/0002", instrValid, memReq, memAddr); end
    endtask

    task automatic test_stall();
        bit ok;
        int bad = 0;
        stall = 1'b1;
        wait_valid(ok);
        checks++; if (!ok || instruction !== 16'h4202 || pcPlus2 !== 16'h0004)
            begin errors++; $display("FAIL stall_instr got %h/%h want 4202/0004", instruction, pcPlus2); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (instrValid !== 1'b1 || instruction !== 16'h4202 || pcPlus2 !== 16'h0004 || memReq !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        stall = 1'b0;
        mem_lat = 4;
        step();
        checks++; if (instrValid !== 1'b0 || memReq !== 1'b1 || memAddr !== 16'h0004)
            begin errors++; $display("FAIL stall_resume got v=%b req=%b addr=%h want 0/1/0004", instrValid, memReq, memAddr); end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        bit seen;
        int n = 0;
        step();
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL rdw_in_wait got memReq=%b want 0", memReq); end
        redirect = 1'b1; redirectPC = 16'h0040;
        step();
        redirect = 1'b0;
        seen = instrValid;
        while (!memReq && n < 20) begin
            step();
            seen |= instrValid;
            n++;
        end
        checks++; if (!memReq || memAddr !== 16'h0040) begin errors++; $display("FAIL rdw_addr got req=%b addr=%h want 1/0040", memReq, memAddr); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rdw_discard got instrValid=%b want 0", seen); end
        mem_lat = 1;
        wait_valid(ok);
        checks++; if (!ok || instruction !== 16'h5A40 || pcPlus2 !== 16'h0042)
            begin errors++; $display("FAIL rdw_instr got %h/%h want 5a40/0042", instruction, pcPlus2); end
    endtask

    task automatic test_halt_redirect();
        bit ok;
        int bad = 0;
        halt = 1'b1; redirect = 1'b1; redirectPC = 16'h0010;
        step();
        halt = 1'b0; redirect = 1'b0;
        checks++; if (instrValid !== 1'b0 || memReq !== 1'b1 || memAddr !== 16'h0010)
            begin errors++; $display("FAIL hr_redirect_wins got v=%b req=%b addr=%h want 0/1/0010", instrValid, memReq, memAddr); end
        wait_valid(ok);
        checks++; if (!ok || instruction !== 16'h5A10 || pcPlus2 !== 16'h0012)
            begin errors++; $display("FAIL hr_instr got %h/%h want 5a10/0012", instruction, pcPlus2); end
        halt = 1'b1;
        step();
        halt = 1'b0;
        checks++; if (instrValid !== 1'b0 || memReq !== 1'b0) begin errors++; $display("FAIL halt_enter got v=%b req=%b want 0/0", instrValid, memReq); end
        for (int i = 0; i < 20; i++) begin
            step();
            if (memReq !== 1'b0 || instrValid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL halt_quiet got %0d active cycles want 0", bad); end
    endtask

    task automatic test_misaligned();
        bit ok;
        int bad = 0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        wait_req(ok);
        checks++; if (!ok || memAddr !== 16'h0000) begin errors++; $display("FAIL mis_restart got %h want 0000", memAddr); end
        redirect = 1'b1; redirectPC = 16'h0013;
        step();
        redirect = 1'b0;
        checks++; if (err !== 1'b1 || memReq !== 1'b0 || instrValid !== 1'b0)
            begin errors++; $display("FAIL mis_err got err=%b req=%b v=%b want 1/0/0", err, memReq, instrValid); end
        redirect = 1'b1; redirectPC = 16'h0020;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (err !== 1'b1 || memReq !== 1'b0 || instrValid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mis_sticky got %0d bad cycles want 0", bad); end
        checks++; if (memAddr[0] !== 1'b0) begin errors++; $display("FAIL mis_addr_even got %h want even", memAddr); end
        rst = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_reset_clears got err=%b want 0", err); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_wrap_and_async_reset();
        bit ok;
        wait_valid(ok);
        checks++; if (!ok || instruction !== 16'h4101) begin errors++; $display("FAIL wrap_first got %h want 4101", instruction); end
        redirect = 1'b1; redirectPC = 16'hFFFE;
        step();
        redirect = 1'b0;
        checks++; if (memReq !== 1'b1 || memAddr !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr got req=%b addr=%h want 1/fffe", memReq, memAddr); end
        wait_valid(ok);
        checks++; if (!ok || instruction !== 16'hA5FE || pcPlus2 !== 16'h0000 || err !== 1'b0)
            begin errors++; $display("FAIL wrap_pcplus2 got %h/%h err=%b want a5fe/0000/0", instruction, pcPlus2, err); end
        step();
        checks++; if (memReq !== 1'b1 || memAddr !== 16'h0000) begin errors++; $display("FAIL wrap_next got req=%b addr=%h want 1/0000", memReq, memAddr); end
        wait_valid(ok);
        checks++; if (!ok || pcPlus2 !== 16'h0002) begin errors++; $display("FAIL wrap_after got %h want 0002", pcPlus2); end
        mem_lat = 4;
        step();
        step();
        checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL ar_in_wait got memReq=%b want 0", memReq); end
        rst = 1'b0;
        #1;
        checks++; if (memReq !== 1'b0 || instrValid !== 1'b0 || instruction !== 16'h0800 || pcPlus2 !== 16'h0000 || err !== 1'b0)
            begin errors++; $display("FAIL ar_async got req=%b v=%b ins=%h pc2=%h err=%b want 0/0/0800/0000/0",
                                     memReq, instrValid, instruction, pcPlus2, err); end
        step();
        rst = 1'b1;
        mem_lat = 1;
        wait_valid(ok);
        checks++; if (!ok || instruction !== 16'h4101 || pcPlus2 !== 16'h0002)
            begin errors++; $display("FAIL ar_late_valid got %h/%h want 4101/0002", instruction, pcPlus2); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i << 1) ^ 16'h5A00;
        mem[0] = 16'h4101;
        mem[1] = 16'h4202;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_halt_redirect();
        test_misaligned();
        test_wrap_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before tests completed");
        $fatal(1, "watchdog");
    end

endmodule
